// File: rtl/phy_rx_packet_decoder.sv
// Receive-side packet decoder: ordered-set detection, 4b5b data decode, CRC32 check,
// EOP/length/timeout flags. All outputs are registered.
module phy_rx_packet_decoder #(
  parameter int unsigned RX_TIMEOUT  = 1000,
  parameter int unsigned MAX_NIBBLES = 68
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       phy_control_tx_rx_select,
  input  logic       phy_control_tx_rx_clr,
  input  logic       phy_rx_symbol_en,
  input  logic [4:0] phy_rx_symbol,
  output logic       phy_control_rx_packet_en,
  output logic [2:0] phy_control_rx_packet_type,
  output logic       phy_control_rx_paylaod_en,
  output logic [3:0] phy_control_rx_paylaod,
  output logic       phy_control_rx_packet_eop,
  output logic       phy_control_rx_packet_crc_error,
  output logic       phy_control_rx_packet_payload_error,
  output logic       phy_control_rx_packet_timeout
);

  localparam int unsigned TmoW = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned CntW = $clog2(MAX_NIBBLES + 1);

  localparam logic [4:0] SymSync1 = 5'b11000;
  localparam logic [4:0] SymSync2 = 5'b10001;
  localparam logic [4:0] SymSync3 = 5'b00110;
  localparam logic [4:0] SymRst1  = 5'b00111;
  localparam logic [4:0] SymRst2  = 5'b11001;
  localparam logic [4:0] SymEop   = 5'b01101;

  localparam logic [31:0] CrcPoly    = 32'h04C11DB7;
  localparam logic [31:0] CrcResidue = 32'hC704DD7B;

  typedef enum logic [0:0] {StHunt, StData} state_e;

  state_e            state_q, state_d;
  logic [19:0]       win_q, win_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        ndo_q, ndo_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [31:0]       crc_q, crc_d;
  logic              pkt_en_q, pkt_en_d;
  logic [2:0]        type_q, type_d;
  logic              pl_en_q, pl_en_d;
  logic [3:0]        pl_q, pl_d;
  logic              eop_q, eop_d;
  logic              crc_err_q, crc_err_d;
  logic              pl_err_q, pl_err_d;
  logic              tmo_q, tmo_d;

  // Window holds the last four symbols, oldest in the top field.
  function automatic logic os_match(input logic [19:0] win, input logic [19:0] pat);
    logic [2:0] hits;
    hits = '0;
    for (int i = 0; i < 4; i++) begin
      if (win[5*i +: 5] == pat[5*i +: 5]) hits = hits + 3'd1;
    end
    return hits >= 3'd3;
  endfunction

  // Register is kept MSB-first; nibble bits enter LSB first.
  function automatic logic [31:0] crc_nibble(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[31] ^ nib[i]) c = {c[30:0], 1'b0} ^ CrcPoly;
      else                c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  logic       data_vld;
  logic [3:0] data_nib;

  always_comb begin
    data_vld = 1'b1;
    data_nib = 4'h0;
    case (phy_rx_symbol)
      5'b11110: data_nib = 4'h0;
      5'b01001: data_nib = 4'h1;
      5'b10100: data_nib = 4'h2;
      5'b10101: data_nib = 4'h3;
      5'b01010: data_nib = 4'h4;
      5'b01011: data_nib = 4'h5;
      5'b01110: data_nib = 4'h6;
      5'b01111: data_nib = 4'h7;
      5'b10010: data_nib = 4'h8;
      5'b10011: data_nib = 4'h9;
      5'b10110: data_nib = 4'hA;
      5'b10111: data_nib = 4'hB;
      5'b11010: data_nib = 4'hC;
      5'b11011: data_nib = 4'hD;
      5'b11100: data_nib = 4'hE;
      5'b11101: data_nib = 4'hF;
      default:  data_vld = 1'b0;
    endcase
  end

  logic [19:0]     win_shift;
  logic [4:0]      os_hit;
  logic [2:0]      os_type;
  logic [CntW-1:0] exp_cnt;

  assign win_shift = {win_q[14:0], phy_rx_symbol};
  assign os_hit[0] = os_match(win_shift, {SymSync1, SymSync1, SymSync1, SymSync2});
  assign os_hit[1] = os_match(win_shift, {SymSync1, SymSync1, SymSync3, SymSync3});
  assign os_hit[2] = os_match(win_shift, {SymSync1, SymSync3, SymSync1, SymSync3});
  assign os_hit[3] = os_match(win_shift, {SymRst1, SymRst1, SymRst1, SymRst2});
  assign os_hit[4] = os_match(win_shift, {SymRst1, SymSync1, SymRst1, SymSync3});
  assign exp_cnt   = CntW'(12) + CntW'({ndo_q, 3'b000});

  always_comb begin
    os_type = 3'd4;
    if      (os_hit[0]) os_type = 3'd0;
    else if (os_hit[1]) os_type = 3'd1;
    else if (os_hit[2]) os_type = 3'd2;
    else if (os_hit[3]) os_type = 3'd3;
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    ndo_d     = ndo_q;
    tmo_cnt_d = tmo_cnt_q;
    crc_d     = crc_q;
    pkt_en_d  = 1'b0;
    type_d    = type_q;
    pl_en_d   = 1'b0;
    pl_d      = pl_q;
    eop_d     = 1'b0;
    crc_err_d = crc_err_q;
    pl_err_d  = 1'b0;
    tmo_d     = 1'b0;

    if (phy_control_tx_rx_select || phy_control_tx_rx_clr) begin
      state_d   = StHunt;
      win_d     = '0;
      cnt_d     = '0;
      tmo_cnt_d = '0;
      crc_err_d = 1'b0;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (phy_rx_symbol_en) begin
            win_d = win_shift;
            if (|os_hit) begin
              pkt_en_d  = 1'b1;
              type_d    = os_type;
              win_d     = '0;
              crc_err_d = 1'b0;
              if (os_type <= 3'd2) begin
                state_d   = StData;
                crc_d     = '1;
                cnt_d     = '0;
                ndo_d     = '0;
                tmo_cnt_d = '0;
              end
            end
          end
        end
        StData: begin
          if (phy_rx_symbol_en) begin
            tmo_cnt_d = '0;
            if (data_vld) begin
              if (cnt_q == CntW'(MAX_NIBBLES)) begin
                pl_err_d = 1'b1;
                state_d  = StHunt;
              end else begin
                pl_en_d = 1'b1;
                pl_d    = data_nib;
                cnt_d   = cnt_q + 1'b1;
                crc_d   = crc_nibble(crc_q, data_nib);
                // Fourth nibble carries the data-object count in bits [2:0].
                if (cnt_q == CntW'(3)) ndo_d = data_nib[2:0];
              end
            end else if (phy_rx_symbol == SymEop) begin
              eop_d     = 1'b1;
              crc_err_d = (crc_q != CrcResidue);
              pl_err_d  = (cnt_q < CntW'(4)) || (cnt_q != exp_cnt);
              state_d   = StHunt;
            end else begin
              pl_err_d = 1'b1;
              state_d  = StHunt;
            end
          end else begin
            if (tmo_cnt_q != TmoW'(RX_TIMEOUT)) tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_cnt_d == TmoW'(RX_TIMEOUT)) begin
              tmo_d   = 1'b1;
              state_d = StHunt;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StHunt;
      win_q     <= '0;
      cnt_q     <= '0;
      ndo_q     <= '0;
      tmo_cnt_q <= '0;
      crc_q     <= '1;
      pkt_en_q  <= 1'b0;
      type_q    <= 3'd0;
      pl_en_q   <= 1'b0;
      pl_q      <= 4'h0;
      eop_q     <= 1'b0;
      crc_err_q <= 1'b0;
      pl_err_q  <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      ndo_q     <= ndo_d;
      tmo_cnt_q <= tmo_cnt_d;
      crc_q     <= crc_d;
      pkt_en_q  <= pkt_en_d;
      type_q    <= type_d;
      pl_en_q   <= pl_en_d;
      pl_q      <= pl_d;
      eop_q     <= eop_d;
      crc_err_q <= crc_err_d;
      pl_err_q  <= pl_err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign phy_control_rx_packet_en            = pkt_en_q;
  assign phy_control_rx_packet_type          = type_q;
  assign phy_control_rx_paylaod_en           = pl_en_q;
  assign phy_control_rx_paylaod              = pl_q;
  assign phy_control_rx_packet_eop           = eop_q;
  assign phy_control_rx_packet_crc_error     = crc_err_q;
  assign phy_control_rx_packet_payload_error = pl_err_q;
  assign phy_control_rx_packet_timeout       = tmo_q;

endmodule

// File: tb/tb_phy_rx_packet_decoder.sv
// Randomised bench for phy_rx_packet_decoder against a queue-based packet model,
// plus directed packet scenarios.
module tb_phy_rx_packet_decoder;

  localparam int unsigned RxTimeout  = 1000;
  localparam int unsigned MaxNibbles = 68;

  localparam logic [4:0] KS1  = 5'b11000;
  localparam logic [4:0] KS2  = 5'b10001;
  localparam logic [4:0] KS3  = 5'b00110;
  localparam logic [4:0] KR1  = 5'b00111;
  localparam logic [4:0] KR2  = 5'b11001;
  localparam logic [4:0] KEop = 5'b01101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tx_sel, tx_clr, sym_en;
  logic [4:0] sym;
  logic       pkt_en, pl_en, eop, crc_err, pl_err, tmo;
  logic [2:0] pkt_type;
  logic [3:0] pl;

  phy_rx_packet_decoder #(
    .RX_TIMEOUT (RxTimeout),
    .MAX_NIBBLES(MaxNibbles)
  ) u_dut (
    .clk                                (clk),
    .rst_n                              (rst_n),
    .phy_control_tx_rx_select           (tx_sel),
    .phy_control_tx_rx_clr              (tx_clr),
    .phy_rx_symbol_en                   (sym_en),
    .phy_rx_symbol                      (sym),
    .phy_control_rx_packet_en           (pkt_en),
    .phy_control_rx_packet_type         (pkt_type),
    .phy_control_rx_paylaod_en          (pl_en),
    .phy_control_rx_paylaod             (pl),
    .phy_control_rx_packet_eop          (eop),
    .phy_control_rx_packet_crc_error    (crc_err),
    .phy_control_rx_packet_payload_error(pl_err),
    .phy_control_rx_packet_timeout      (tmo)
  );

  logic [4:0] data_code [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011,
                                 5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                 5'b11010, 5'b11011, 5'b11100, 5'b11101};
  logic [4:0] os_tab [5][4] = '{'{KS1, KS1, KS1, KS2}, '{KS1, KS1, KS3, KS3},
                                '{KS1, KS3, KS1, KS3}, '{KR1, KR1, KR1, KR2},
                                '{KR1, KS1, KR1, KS3}};
  logic [4:0] bad_tab [4] = '{5'b00000, 5'b11111, KS1, KR2};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: packet-level view built from queues.
  bit         m_data;
  logic [4:0] m_hist[$];
  logic [3:0] m_pkt[$];
  int         m_idle;
  logic       e_pkt_en, e_pl_en, e_eop, e_crc_err, e_pl_err, e_tmo;
  logic [2:0] e_type;
  logic [3:0] e_pl;

  // Standard reflected CRC-32 step, LSB first.
  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[0] ^ n[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Good packet leaves the reflected register at the bit-reversed residue.
  function automatic bit crc_ok();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (m_pkt[i]) c = crc_ref(c, m_pkt[i]);
    return c == 32'hDEBB20E3;
  endfunction

  function automatic int data_index(input logic [4:0] s);
    for (int i = 0; i < 16; i++) if (data_code[i] == s) return i;
    return -1;
  endfunction

  task automatic hist_clear();
    m_hist = '{5'd0, 5'd0, 5'd0, 5'd0};
  endtask

  task automatic model_step(input bit en, input logic [4:0] s, input bit hold, input bit rst);
    int idx;
    int hits;
    e_pkt_en = 0; e_pl_en = 0; e_eop = 0; e_pl_err = 0; e_tmo = 0;
    if (rst) begin
      m_data = 0; hist_clear(); m_pkt = {}; m_idle = 0;
      e_type = 0; e_pl = 0; e_crc_err = 0;
    end else if (hold) begin
      m_data = 0; hist_clear(); m_idle = 0; e_crc_err = 0;
    end else if (!m_data) begin
      if (en) begin
        m_hist.push_back(s);
        void'(m_hist.pop_front());
        for (int t = 0; t < 5; t++) begin
          hits = 0;
          for (int i = 0; i < 4; i++) if (m_hist[i] == os_tab[t][i]) hits++;
          if (hits >= 3) begin
            e_pkt_en = 1; e_type = 3'(t); e_crc_err = 0; hist_clear();
            if (t <= 2) begin m_data = 1; m_pkt = {}; m_idle = 0; end
            break;
          end
        end
      end
    end else if (en) begin
      m_idle = 0;
      idx = data_index(s);
      if (idx >= 0) begin
        if (m_pkt.size() == MaxNibbles) begin
          e_pl_err = 1; m_data = 0;
        end else begin
          m_pkt.push_back(4'(idx)); e_pl_en = 1; e_pl = 4'(idx);
        end
      end else if (s == KEop) begin
        e_eop = 1;
        e_crc_err = !crc_ok();
        if (m_pkt.size() < 4) e_pl_err = 1;
        else e_pl_err = (m_pkt.size() != 12 + 8 * int'(m_pkt[3][2:0]));
        m_data = 0;
      end else begin
        e_pl_err = 1; m_data = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == RxTimeout) begin e_tmo = 1; m_data = 0; end
    end
  endtask

  int o_pkt = 0, o_pl = 0, o_eop = 0, o_plerr = 0, o_tmo = 0;

  task automatic tick(input bit en, input logic [4:0] s, input bit clr, input bit sel);
    sym_en = en; sym = s; tx_clr = clr; tx_sel = sel;
    model_step(en, s, clr | sel, !rst_n);
    @(posedge clk);
    #1;
    check("packet_en", 32'(pkt_en), 32'(e_pkt_en));
    check("packet_type", 32'(pkt_type), 32'(e_type));
    check("paylaod_en", 32'(pl_en), 32'(e_pl_en));
    check("paylaod", 32'(pl), 32'(e_pl));
    check("eop", 32'(eop), 32'(e_eop));
    check("crc_error", 32'(crc_err), 32'(e_crc_err));
    check("payload_error", 32'(pl_err), 32'(e_pl_err));
    check("timeout", 32'(tmo), 32'(e_tmo));
    o_pkt += int'(pkt_en); o_pl += int'(pl_en); o_eop += int'(eop);
    o_plerr += int'(pl_err); o_tmo += int'(tmo);
    sym_en = 0; tx_clr = 0; tx_sel = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 5'd0, 0, 0);
  endtask

  task automatic gap();
    idle($urandom_range(0, 2));
  endtask

  task automatic send_os(input int t);
    for (int i = 0; i < 4; i++) tick(1, os_tab[t][i], 0, 0);
  endtask

  logic [3:0] tx_pkt[$];

  task automatic append_crc();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (tx_pkt[i]) c = crc_ref(c, tx_pkt[i]);
    c = ~c;
    for (int k = 0; k < 8; k++) tx_pkt.push_back(c[4*k +: 4]);
  endtask

  task automatic build_pkt(input int ndo);
    tx_pkt = {};
    for (int i = 0; i < 3; i++) tx_pkt.push_back(4'($urandom_range(0, 15)));
    tx_pkt.push_back({1'($urandom_range(0, 1)), 3'(ndo)});
    for (int i = 0; i < 8 * ndo; i++) tx_pkt.push_back(4'($urandom_range(0, 15)));
    append_crc();
  endtask

  task automatic send_nibbles(input bit gaps);
    foreach (tx_pkt[i]) begin
      tick(1, data_code[tx_pkt[i]], 0, 0);
      if (gaps) gap();
    end
  endtask

  int p0, p1, p2;

  initial begin
    rst_n = 0; tx_sel = 0; tx_clr = 0; sym_en = 0; sym = '0;
    hist_clear(); m_data = 0; m_idle = 0;
    idle(2);
    check("rst_crc_error", 32'(crc_err), 32'd0);
    rst_n = 1;
    idle(2);

    // Clean SOP packet, header 1,4,0,0.
    send_os(0);
    check("c1_packet_en", 32'(pkt_en), 32'd1);
    check("c1_type", 32'(pkt_type), 32'd0);
    tx_pkt = '{4'h1, 4'h4, 4'h0, 4'h0};
    append_crc();
    p0 = o_pl;
    send_nibbles(1);
    check("c1_nibble_count", 32'(o_pl - p0), 32'd12);
    tick(1, KEop, 0, 0);
    check("c1_eop", 32'(eop), 32'd1);
    check("c1_crc_error", 32'(crc_err), 32'd0);
    check("c1_payload_error", 32'(pl_err), 32'd0);
    idle(3);

    // Hard Reset with one corrupted position.
    tick(1, KR1, 0, 0); tick(1, KS1, 0, 0); tick(1, KR1, 0, 0); tick(1, KR2, 0, 0);
    check("c2_packet_en", 32'(pkt_en), 32'd1);
    check("c2_type", 32'(pkt_type), 32'd3);
    p0 = o_pl;
    for (int i = 0; i < 6; i++) tick(1, data_code[i], 0, 0);
    check("c2_no_payload", 32'(o_pl - p0), 32'd0);
    idle(2);

    // Same packet with the last CRC nibble flipped.
    send_os(0);
    tx_pkt = '{4'h1, 4'h4, 4'h0, 4'h0};
    append_crc();
    tx_pkt[11] = tx_pkt[11] ^ 4'h1;
    send_nibbles(0);
    tick(1, KEop, 0, 0);
    check("c3_eop", 32'(eop), 32'd1);
    check("c3_crc_error", 32'(crc_err), 32'd1);
    check("c3_payload_error", 32'(pl_err), 32'd0);
    idle(1);
    check("c3_crc_error_held", 32'(crc_err), 32'd1);

    // SOP', header claims one data object, only 12 nibbles sent.
    send_os(1);
    check("c4_type", 32'(pkt_type), 32'd1);
    check("c4_crc_error_cleared", 32'(crc_err), 32'd0);
    tx_pkt = '{4'h3, 4'h2, 4'h7, 4'h1};
    append_crc();
    send_nibbles(1);
    tick(1, KEop, 0, 0);
    check("c4_eop", 32'(eop), 32'd1);
    check("c4_payload_error", 32'(pl_err), 32'd1);
    idle(2);

    // SOP'' then an invalid symbol.
    send_os(2);
    tick(1, 5'b00000, 0, 0);
    check("c5_payload_error", 32'(pl_err), 32'd1);
    p0 = o_pl; p1 = o_plerr;
    for (int i = 0; i < 8; i++) tick(1, data_code[15 - i], 0, 0);
    tick(1, KEop, 0, 0);
    check("c5_ignored_payload", 32'(o_pl - p0), 32'd0);
    check("c5_ignored_error", 32'(o_plerr - p1), 32'd0);
    idle(2);

    // Timeout after 5 nibbles.
    send_os(0);
    p0 = o_tmo;
    for (int i = 0; i < 5; i++) tick(1, data_code[i + 3], 0, 0);
    idle(RxTimeout + 10);
    check("c6_timeout_pulses", 32'(o_tmo - p0), 32'd1);

    // Clear after nibble 3 suppresses the timeout.
    send_os(0);
    p0 = o_tmo; p1 = o_eop; p2 = o_plerr;
    for (int i = 0; i < 3; i++) tick(1, data_code[i + 7], 0, 0);
    tick(0, 5'd0, 1, 0);
    idle(RxTimeout + 10);
    check("c7_no_timeout", 32'(o_tmo - p0), 32'd0);
    check("c7_no_eop", 32'(o_eop - p1), 32'd0);
    check("c7_no_error", 32'(o_plerr - p2), 32'd0);
    p0 = o_pkt;
    send_os(0);
    check("c7_next_sop", 32'(o_pkt - p0), 32'd1);
    build_pkt(2);
    send_nibbles(1);
    tick(1, KEop, 0, 0);
    check("c7_eop_clean", 32'({eop, crc_err, pl_err}), 32'b100);

    // Longest packet plus one nibble overflows.
    send_os(0);
    build_pkt(7);
    tx_pkt.push_back(4'h5);
    p0 = o_plerr; p1 = o_eop;
    send_nibbles(0);
    tick(1, KEop, 0, 0);
    check("c8_overflow_error", 32'(o_plerr - p0), 32'd1);
    check("c8_overflow_no_eop", 32'(o_eop - p1), 32'd0);

    // Reset mid-packet.
    send_os(1);
    for (int i = 0; i < 4; i++) tick(1, data_code[i], 0, 0);
    rst_n = 0;
    tick(0, 5'd0, 0, 0);
    rst_n = 1;
    p0 = o_eop; p1 = o_plerr; p2 = o_tmo;
    tick(1, data_code[1], 0, 0);
    tick(1, KEop, 0, 0);
    idle(5);
    check("c9_reset_quiet", 32'((o_eop - p0) + (o_plerr - p1) + (o_tmo - p2)), 32'd0);
    check("c9_reset_type", 32'(pkt_type), 32'd0);

    // TX mode holds the decoder in HUNT.
    p0 = o_pkt;
    for (int i = 0; i < 4; i++) tick(1, os_tab[0][i], 0, 1);
    check("c10_tx_hold", 32'(o_pkt - p0), 32'd0);

    // Randomised packets with assorted corruptions.
    for (int it = 0; it < 60; it++) begin
      int t, m, pos;
      t = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) begin
        logic [4:0] s;
        s = os_tab[t][i];
        if ($urandom_range(0, 7) == 0) s = os_tab[$urandom_range(0, 4)][$urandom_range(0, 3)];
        tick(1, s, 0, 0);
        gap();
      end
      build_pkt($urandom_range(0, 7));
      m = $urandom_range(0, 7);
      pos = $urandom_range(0, tx_pkt.size() - 1);
      if (m == 0) tx_pkt[pos] = tx_pkt[pos] ^ 4'(1 << $urandom_range(0, 3));
      if (m == 1) void'(tx_pkt.pop_back());
      if (m == 2) tx_pkt.push_back(4'($urandom_range(0, 15)));
      foreach (tx_pkt[i]) begin
        if (i == pos && m == 3) tick(1, bad_tab[$urandom_range(0, 3)], 0, 0);
        if (i == pos && m == 4) tick(0, 5'd0, 1, 0);
        if (i == pos && m == 5) tick(1, data_code[tx_pkt[i]], 0, 1);
        tick(1, data_code[tx_pkt[i]], 0, 0);
        gap();
      end
      tick(1, KEop, 0, 0);
      idle($urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
